mem_stage: RTL and testbench

//  Pipeline stage directly downstream of execute. Takes one executed instruction per i_ready pulse.

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Execute-side instruction bus plus data-memory handshake and writeback outputs of the memory stage.
// The slave modport is the stage itself. The master modport is the execute/memory/regfile side.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32
);
  logic                  i_flush;
  logic                  i_stall;
  logic                  i_ready;
  logic [3:0]            i_opcode;
  logic [5:0]            i_operand1;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [WORD_WIDTH-1:0] i_wdata;
  logic [WORD_WIDTH-1:0] i_result;
  logic                  i_wb_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [WORD_WIDTH-1:0] o_mem_wdata;
  logic                  o_mem_write;
  logic                  o_mem_req;
  logic                  i_mem_ack;
  logic [WORD_WIDTH-1:0] i_mem_rdata;
  logic                  o_busy;
  logic                  o_ready;
  logic                  o_wb_en;
  logic [5:0]            o_wb_reg;
  logic [WORD_WIDTH-1:0] o_wb_data;
  logic                  o_fault;

  modport slave (
    input  i_flush, i_stall, i_ready, i_opcode, i_operand1, i_addr, i_wdata,
           i_result, i_wb_req, i_mem_ack, i_mem_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_write, o_mem_req, o_busy, o_ready,
           o_wb_en, o_wb_reg, o_wb_data, o_fault
  );

  modport master (
    output i_flush, i_stall, i_ready, i_opcode, i_operand1, i_addr, i_wdata,
           i_result, i_wb_req, i_mem_ack, i_mem_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_write, o_mem_req, o_busy, o_ready,
           o_wb_en, o_wb_reg, o_wb_data, o_fault
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: retires ALU results in one cycle, runs LDM/STM over a req/ack bus with timeout,
// and presents a single writeback to the register file.
module mem_stage #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WORD_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input logic         i_clk,
  input logic         i_rst_n,
  mem_stage_if.slave  bus
);
  localparam logic [3:0] OP_LDM = 4'h7;
  localparam logic [3:0] OP_STM = 4'h6;
  localparam int         CW     = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  write;
    logic [5:0]            rd;
  } mreq_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  flushed, flushed_n;
  logic                  req, req_n;
  mreq_t                 mreq, mreq_n;
  logic                  ready, ready_n;
  logic                  wb_en, wb_en_n;
  logic [5:0]            wb_reg, wb_reg_n;
  logic [WORD_WIDTH-1:0] wb_data, wb_data_n;
  logic                  fault, fault_n;
  logic                  is_mem, accept;

  assign is_mem = (bus.i_opcode == OP_LDM) || (bus.i_opcode == OP_STM);
  assign accept = (state == IDLE) && bus.i_ready && !bus.i_stall && !bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      flushed <= 1'b0;
      req     <= 1'b0;
      mreq    <= '0;
      ready   <= 1'b0;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      flushed <= flushed_n;
      req     <= req_n;
      mreq    <= mreq_n;
      ready   <= ready_n;
      wb_en   <= wb_en_n;
      wb_reg  <= wb_reg_n;
      wb_data <= wb_data_n;
      fault   <= fault_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    flushed_n = flushed;
    req_n     = req;
    mreq_n    = mreq;
    ready_n   = 1'b0;
    wb_en_n   = 1'b0;
    wb_reg_n  = wb_reg;
    wb_data_n = wb_data;
    fault_n   = fault;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            ready_n   = 1'b1;
            wb_en_n   = bus.i_wb_req;
            wb_reg_n  = bus.i_operand1;
            wb_data_n = bus.i_result;
          end else if (bus.i_addr[1:0] != 2'b00) begin
            fault_n = 1'b1;
            ready_n = 1'b1;
          end else begin
            mreq_n    = '{addr: bus.i_addr, wdata: bus.i_wdata,
                          write: (bus.i_opcode == OP_STM), rd: bus.i_operand1};
            req_n     = 1'b1;
            cnt_n     = '0;
            flushed_n = 1'b0;
            state_n   = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        // Ack wins over timeout when both land on the last allowed cycle.
        if (bus.i_mem_ack) begin
          req_n   = 1'b0;
          ready_n = 1'b1;
          state_n = IDLE;
          if (!mreq.write && !(flushed || bus.i_flush)) begin
            wb_en_n   = 1'b1;
            wb_reg_n  = mreq.rd;
            wb_data_n = bus.i_mem_rdata;
          end
        end else begin
          cnt_n     = cnt + 1'b1;
          flushed_n = flushed || bus.i_flush;
          if (cnt_n == CW'(MEM_TIMEOUT)) begin
            cnt_n   = '0;
            req_n   = 1'b0;
            fault_n = 1'b1;
            ready_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_busy      = (state == MEM_WAIT);
  assign bus.o_mem_req   = req;
  assign bus.o_mem_addr  = mreq.addr;
  assign bus.o_mem_wdata = mreq.wdata;
  assign bus.o_mem_write = mreq.write;
  assign bus.o_ready     = ready;
  assign bus.o_wb_en     = wb_en;
  assign bus.o_wb_reg    = wb_reg;
  assign bus.o_wb_data   = wb_data;
  assign bus.o_fault     = fault;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction's outcome is predicted at transaction level
// (latency, writeback, fault) and checked cycle by cycle.
module tb_mem_stage;
  localparam int AW  = 12;
  localparam int WW  = 32;
  localparam int TMO = 15;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  logic          exp_fault;
  logic [5:0]    exp_reg;
  logic [WW-1:0] exp_data;

  mem_stage_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  mem_stage #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_TIMEOUT(TMO)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    bus.i_flush = 1'b0; bus.i_stall = 1'b0; bus.i_ready = 1'b0;
    bus.i_opcode = '0; bus.i_operand1 = '0; bus.i_addr = '0;
    bus.i_wdata = '0; bus.i_result = '0; bus.i_wb_req = 1'b0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rand_fields();
    bus.i_opcode   = 4'($urandom);
    bus.i_operand1 = 6'($urandom);
    bus.i_addr     = AW'($urandom);
    bus.i_wdata    = $urandom;
    bus.i_result   = $urandom;
    bus.i_wb_req   = 1'($urandom);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'd0);
    chk({tag, ".wb_en"}, 64'(bus.o_wb_en), 64'd0);
    chk({tag, ".busy"},  64'(bus.o_busy),  64'd0);
    chk({tag, ".req"},   64'(bus.o_mem_req), 64'd0);
    chk({tag, ".fault"}, 64'(bus.o_fault), 64'(exp_fault));
    chk({tag, ".wbreg"}, 64'(bus.o_wb_reg), 64'(exp_reg));
    chk({tag, ".wbdat"}, 64'(bus.o_wb_data), 64'(exp_data));
  endtask

  // One instruction from acceptance to retirement, then an idle cycle in which accept is blocked.
  task automatic do_op(input logic [3:0] op, input logic [5:0] r, input logic [AW-1:0] a,
                       input logic [WW-1:0] wd, input logic [WW-1:0] res, input logic wbr,
                       input int d, input logic [WW-1:0] rd, input logic nz);
    logic mem, flushed, ld;
    logic [1:0] v;
    mem = (op == 4'h7) || (op == 4'h6);
    ld  = (op == 4'h7);
    bus.i_ready = 1'b1; bus.i_opcode = op; bus.i_operand1 = r; bus.i_addr = a;
    bus.i_wdata = wd; bus.i_result = res; bus.i_wb_req = wbr;
    tick(); clr_in();
    if (!mem) begin
      exp_reg = r; exp_data = res;
      chk("alu.ready", 64'(bus.o_ready), 64'd1);
      chk("alu.wb_en", 64'(bus.o_wb_en), 64'(wbr));
      chk("alu.wbreg", 64'(bus.o_wb_reg), 64'(r));
      chk("alu.wbdat", 64'(bus.o_wb_data), 64'(res));
      chk("alu.busy",  64'(bus.o_busy), 64'd0);
      chk("alu.req",   64'(bus.o_mem_req), 64'd0);
    end else if (a[1:0] != 2'b00) begin
      exp_fault = 1'b1;
      chk("mis.ready", 64'(bus.o_ready), 64'd1);
      chk("mis.wb_en", 64'(bus.o_wb_en), 64'd0);
      chk("mis.fault", 64'(bus.o_fault), 64'd1);
      chk("mis.req",   64'(bus.o_mem_req), 64'd0);
      chk("mis.busy",  64'(bus.o_busy), 64'd0);
    end else begin
      flushed = 1'b0;
      for (int k = 0; k < TMO; k++) begin
        chk("wait.busy",  64'(bus.o_busy), 64'd1);
        chk("wait.req",   64'(bus.o_mem_req), 64'd1);
        chk("wait.addr",  64'(bus.o_mem_addr), 64'(a));
        chk("wait.wdata", 64'(bus.o_mem_wdata), 64'(wd));
        chk("wait.write", 64'(bus.o_mem_write), 64'(!ld));
        chk("wait.ready", 64'(bus.o_ready), 64'd0);
        rand_fields();
        bus.i_mem_ack   = (k == d);
        bus.i_mem_rdata = (k == d) ? rd : $urandom;
        bus.i_flush     = nz && ($urandom_range(0, 7) == 0);
        bus.i_stall     = nz && 1'($urandom);
        bus.i_ready     = nz && 1'($urandom);
        flushed         = flushed | bus.i_flush;
        tick(); clr_in();
        if (k == d) break;
      end
      chk("ret.ready", 64'(bus.o_ready), 64'd1);
      chk("ret.req",   64'(bus.o_mem_req), 64'd0);
      chk("ret.busy",  64'(bus.o_busy), 64'd0);
      if (d < TMO) begin
        chk("ret.wb_en", 64'(bus.o_wb_en), 64'(ld && !flushed));
        if (ld && !flushed) begin
          exp_reg = r; exp_data = rd;
        end
      end else begin
        exp_fault = 1'b1;
        chk("tmo.wb_en", 64'(bus.o_wb_en), 64'd0);
      end
      chk("ret.fault", 64'(bus.o_fault), 64'(exp_fault));
      chk("ret.wbreg", 64'(bus.o_wb_reg), 64'(exp_reg));
      chk("ret.wbdat", 64'(bus.o_wb_data), 64'(exp_data));
    end
    rand_fields();
    bus.i_ready = 1'($urandom);
    if (bus.i_ready) begin
      v = 2'($urandom_range(1, 3));
      bus.i_stall = v[0]; bus.i_flush = v[1];
    end
    tick(); clr_in();
    chk_quiet("gap");
  endtask

  logic [3:0]    r_op;
  logic [AW-1:0] r_a;
  int            r_d, sel;

  initial begin
    clr_in();
    exp_fault = 1'b0; exp_reg = '0; exp_data = '0;
    i_rst_n = 1'b0;
    repeat (3) tick();
    chk_quiet("rst");
    chk("rst.addr", 64'(bus.o_mem_addr), 64'd0);
    chk("rst.wdat", 64'(bus.o_mem_wdata), 64'd0);
    i_rst_n = 1'b1;
    tick();

    do_op(4'h0, 6'd5, '0, '0, 32'h0A, 1'b1, 0, '0, 1'b0);
    do_op(4'h7, 6'd2, 12'h010, '0, '0, 1'b0, 2, 32'hDEADBEEF, 1'b0);
    do_op(4'h6, 6'd9, 12'h020, 32'h12345678, '0, 1'b0, 0, 32'h55AA55AA, 1'b0);
    do_op(4'h7, 6'd3, 12'h013, '0, '0, 1'b0, 0, '0, 1'b0);
    do_op(4'h7, 6'd4, 12'h040, '0, '0, 1'b0, 99, '0, 1'b0);
    do_op(4'h7, 6'd6, 12'h044, '0, '0, 1'b0, TMO - 1, 32'hCAFEF00D, 1'b0);

    bus.i_ready = 1'b1; bus.i_flush = 1'b1; bus.i_opcode = 4'h1;
    bus.i_operand1 = 6'd7; bus.i_result = 32'h77; bus.i_wb_req = 1'b1;
    tick(); clr_in();
    chk_quiet("flush");

    // Reset during an outstanding load must drop everything without waiting for a clock.
    bus.i_ready = 1'b1; bus.i_opcode = 4'h7; bus.i_operand1 = 6'd1; bus.i_addr = 12'h100;
    tick(); clr_in();
    chk("rstw.busy", 64'(bus.o_busy), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    exp_fault = 1'b0; exp_reg = '0; exp_data = '0;
    chk_quiet("rstw");
    chk("rstw.addr", 64'(bus.o_mem_addr), 64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int n = 0; n < 300; n++) begin
      sel  = $urandom_range(0, 3);
      r_op = (sel == 0) ? 4'h7 : (sel == 1) ? 4'h6 : 4'($urandom);
      r_a  = AW'($urandom);
      if ($urandom_range(0, 5) != 0) r_a[1:0] = 2'b00;
      r_d  = $urandom_range(0, TMO + 2);
      do_op(r_op, 6'($urandom), r_a, $urandom, $urandom, 1'($urandom), r_d, $urandom, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
